// File: rtl/iob_wishbone_arbiter.sv
// ============================================================================
// iob_wishbone_arbiter: round-robin arbiter muxing N IOb requesters onto one
// Wishbone classic master. Optional abort timer: IOB_WB_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_wishbone_arbiter #(
    parameter int N_MASTERS   = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                          clk_i,
    input  logic                          cke_i,
    input  logic                          rst_n_i,
    input  logic [N_MASTERS-1:0]          iob_valid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]   iob_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]   iob_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0] iob_wstrb_i,
    output logic [N_MASTERS-1:0]          iob_ready_o,
    output logic [N_MASTERS-1:0]          iob_rvalid_o,
    output logic [DATA_W-1:0]             iob_rdata_o,
    output logic [ADDR_W-1:0]             wb_addr_o,
    output logic [DATA_W-1:0]             wb_data_o,
    output logic [DATA_W/8-1:0]           wb_select_o,
    output logic                          wb_we_o,
    output logic                          wb_cyc_o,
    output logic                          wb_stb_o,
    input  logic                          wb_ack_i,
    input  logic [DATA_W-1:0]             wb_data_i,
    output logic [N_MASTERS-1:0]          grant_o,
    output logic                          timeout_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    if (N_MASTERS < 2 || (DATA_W % 8) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("iob_wishbone_arbiter: illegal parameter combination");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     cand;
    logic               found;
    logic [N_MASTERS-1:0] win_onehot;
    logic [STRB_W-1:0]  win_strb;

`ifdef IOB_WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]   cnt;
    logic               timeout_q;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Search upward from ptr+1 with wrap, so the last owner ranks lowest.
    always_comb begin
        found      = 1'b0;
        win_idx    = '0;
        cand       = '0;
        win_onehot = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_MASTERS)) begin
                cand = cand - (IDX_W+1)'(N_MASTERS);
            end
            if (!found && iob_valid_i[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
        win_onehot[win_idx] = 1'b1;
    end

    assign win_strb = iob_wstrb_i[win_idx*STRB_W +: STRB_W];

    // Ready is withheld whenever the capture edge would not take effect.
    assign iob_ready_o = (state == IDLE && found && rst_n_i && cke_i) ? win_onehot : '0;
    assign wb_stb_o    = wb_cyc_o;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            ptr          <= IDX_W'(N_MASTERS - 1);
            owner        <= '0;
            grant_o      <= '0;
            wb_cyc_o     <= 1'b0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            wb_select_o  <= '0;
            wb_we_o      <= 1'b0;
            iob_rvalid_o <= '0;
            iob_rdata_o  <= '0;
`ifdef IOB_WB_ARB_TIMEOUT_EN
            cnt          <= '0;
            timeout_q    <= 1'b0;
`endif
        end else if (cke_i) begin
            iob_rvalid_o <= '0;
`ifdef IOB_WB_ARB_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        wb_addr_o   <= iob_addr_i[win_idx*ADDR_W +: ADDR_W];
                        wb_data_o   <= iob_wdata_i[win_idx*DATA_W +: DATA_W];
                        wb_we_o     <= |win_strb;
                        wb_select_o <= (|win_strb) ? win_strb : '1;
                        grant_o     <= win_onehot;
                        owner       <= win_idx;
                        wb_cyc_o    <= 1'b1;
                        state       <= BUSY;
`ifdef IOB_WB_ARB_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        grant_o  <= '0;
                        ptr      <= owner;
                        state    <= IDLE;
                        if (!wb_we_o) begin
                            iob_rdata_o         <= wb_data_i;
                            iob_rvalid_o[owner] <= 1'b1;
                        end
                    end
`ifdef IOB_WB_ARB_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        wb_cyc_o  <= 1'b0;
                        grant_o   <= '0;
                        ptr       <= owner;
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                        if (!wb_we_o) begin
                            iob_rdata_o         <= '0;
                            iob_rvalid_o[owner] <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/iob_wishbone_arbiter.md
Name: iob_wishbone_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone master interface among N_MASTERS IOb requesters.
- Each request is registered, then issued as a single Wishbone classic cycle. The read response is routed back to the granting master.
- Sits between several IOb initiators (CPU, DMA, debug) and a single Wishbone slave or interconnect.

Parameters:
- N_MASTERS, 2, number of IOb requester ports (>=2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- TIMEOUT_CYC, 256, Wishbone cycles allowed before abort. Used only with IOB_WB_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- cke_i  in  1  clock enable; all state holds when 0.
- rst_n_i  in  1  reset, synchronous, active-low.
- iob_valid_i  in  N_MASTERS  per-master request valid.
- iob_addr_i  in  N_MASTERS*ADDR_W  flattened addresses; master i at slice [i*ADDR_W +: ADDR_W].
- iob_wdata_i  in  N_MASTERS*DATA_W  flattened write data.
- iob_wstrb_i  in  N_MASTERS*DATA_W/8  flattened write strobes; all zero means read.
- iob_ready_o  out  N_MASTERS  per-master request accept.
- iob_rvalid_o  out  N_MASTERS  per-master read data valid.
- iob_rdata_o  out  DATA_W  read data, shared; qualified by iob_rvalid_o.
- wb_addr_o  out  ADDR_W  Wishbone address.
- wb_data_o  out  DATA_W  Wishbone write data.
- wb_select_o  out  DATA_W/8  Wishbone byte select.
- wb_we_o  out  1  Wishbone write enable.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe; always equal to wb_cyc_o.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_data_i  in  DATA_W  Wishbone read data.
- grant_o  out  N_MASTERS  one-hot owner of the current transaction; 0 in IDLE.
- timeout_o  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge): all outputs 0. FSM goes to IDLE. Round-robin pointer = N_MASTERS-1, so master 0 has first priority.
- FSM has two states: IDLE and BUSY.
- IDLE, arbitration:
  - If any iob_valid_i is set, the winner is the first set bit searching upward from pointer+1, with wrap-around.
  - The winner's iob_ready_o is asserted combinationally in the same cycle; all other ready bits are 0.
  - At the edge: capture the winner's addr, wdata and wstrb.
  - wb_we = |wstrb. wb_select = wstrb for writes, all ones for reads.
  - grant register <= winner; FSM -> BUSY.
- IDLE, no valid: nothing changes; all ready bits 0.
- BUSY:
  - wb_cyc_o = wb_stb_o = 1, driven from the captured registers.
  - All iob_ready_o = 0.
  - On wb_ack_i=1 at an edge:
    - cyc/stb drop the next cycle.
    - Read: wb_data_i is registered to iob_rdata_o, and iob_rvalid_o[owner] is high for exactly one cycle.
    - Write: no rvalid.
    - Pointer <= owner; grant_o <= 0; FSM -> IDLE.
- Latency: accept at cycle 0; stb is first visible in cycle 1; for ack sampled at cycle k, rvalid is in cycle k+1.
- A new grant may occur in the same cycle as rvalid (back-to-back). Best case is one transaction every 2 cycles.
- wb_ack_i while IDLE is ignored.
- Requesters may drop iob_valid_i before being granted; no request is latched unless ready was given.
- Ownership is round-robin fair: a master that was just served has lowest priority next time.
- Reset asserted mid-transaction: cyc/stb are 0 after the edge and the pending response is discarded (no rvalid). The slave's later ack is ignored.
- cke_i=0: registers and FSM freeze; combinational ready stays gated by the frozen state.

Optional Feature:
- Macro: IOB_WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC without ack: cyc/stb drop, timeout_o pulses for 1 cycle, FSM -> IDLE, pointer <= owner.
  - Read abort: iob_rvalid_o[owner] pulses with iob_rdata_o = 0. Write abort: silent.
  - An ack in the same cycle as the timeout wins; timeout_o is not pulsed.
- Undefined: no counter; BUSY waits indefinitely; timeout_o is tied 0.

Test Plan:
- Single read: master 1 requests addr 0x10 with wstrb 0. Slave acks after 3 cycles with 0xCAFEF00D. Expect: ready[1] in cycle 0; wb_select 0xF and we 0; rvalid[1] for one cycle with rdata 0xCAFEF00D; grant_o 0b10 during BUSY.
- Write: master 0 writes 0x12345678 to 0x20 with wstrb 0x3. Expect: wb_we 1, wb_select 0x3, data 0x12345678; no rvalid; returns to IDLE after ack.
- Contention: N_MASTERS=3, all masters valid continuously with 1-cycle-ack writes. Expect grant order 0,1,2,0,1,2, one grant every 2 cycles.
- Back-to-back: master 0 read ack coincides with master 2 waiting. Expect rvalid[0] and ready[2] in the same cycle.
- Reset mid-cycle: assert rst_n_i=0 during BUSY, before ack. Expect cyc/stb/grant 0 next cycle and no rvalid; a late ack is ignored.
- Timeout (macro on, TIMEOUT_CYC=8): read with no ack. Expect timeout_o pulse after 8 BUSY cycles, rvalid with rdata 0, and the next request granted normally.
